// File: rtl/pedestrian_crossing_unit_pkg.sv
// rtl/pedestrian_crossing_unit_pkg.sv - shared states, light codes and decode helper for the crossing unit
package pedestrian_crossing_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQUESTED,
        WAIT_RED,
        WALK,
        CLEAR,
        FAULT
    } ped_state_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Exactly one of R/Y/G lit is the only legal controller output.
    function automatic logic light_legal(input logic [2:0] ryg);
        return (ryg == LIGHT_RED) || (ryg == LIGHT_YELLOW) || (ryg == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/pedestrian_crossing_unit_if.sv
// rtl/pedestrian_crossing_unit_if.sv - link between traffic_light_controller and the crossing unit
interface pedestrian_crossing_unit_if;

    logic red_light_active;
    logic yellow_light_active;
    logic green_light_active;
    logic pedestrian_button_pressed;

    modport master (
        output red_light_active,
        output yellow_light_active,
        output green_light_active,
        input  pedestrian_button_pressed
    );

    modport slave (
        input  red_light_active,
        input  yellow_light_active,
        input  green_light_active,
        output pedestrian_button_pressed
    );

endinterface

// File: rtl/pedestrian_crossing_unit_button_debouncer.sv
// rtl/pedestrian_crossing_unit_button_debouncer.sv - kerb button synchronizer and press qualifier
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock_signal,
    input  logic reset_n_signal,
    input  logic raw_button_input,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    // Count consecutive high samples, saturating so a held button fires only once.
    always_comb begin
        sync1_d = raw_button_input;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        pulse_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end

    // Register synchronizer, counter and the single-cycle press pulse.
    always_ff @(posedge clock_signal) begin
        if (!reset_n_signal) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/pedestrian_crossing_unit.sv
// rtl/pedestrian_crossing_unit.sv - pedestrian lamps, request and light-fault supervision
module pedestrian_crossing_unit
    import pedestrian_crossing_unit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 8,
    parameter int CLEAR_CYCLES    = 6
) (
    input  logic                                  clock_signal,
    input  logic                                  reset_n_signal,
    input  logic                                  raw_button_input,
    pedestrian_crossing_unit_if.slave             link,
    output logic                                  walk_light_active,
    output logic                                  dont_walk_light_active,
    output logic [$clog2(CLEAR_CYCLES+1)-1:0]     clearance_countdown,
    output logic                                  light_fault_detected
);

    localparam int TW = $clog2(WALK_CYCLES + 1);
    localparam int DW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [TW-1:0] WALK_LAST = TW'(WALK_CYCLES - 1);
    localparam logic [DW-1:0] CLEAR_MAX = DW'(CLEAR_CYCLES);

    logic          press;
    logic          red, yellow, green, legal, red_rise;
    ped_state_e    state_q, state_d;
    logic          request_q, request_d;
    logic          walk_q, walk_d;
    logic          dont_walk_q, dont_walk_d;
    logic [DW-1:0] cd_q, cd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic          fault_q, fault_d;
    logic          red_prev_q, red_prev_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clock_signal     (clock_signal),
        .reset_n_signal   (reset_n_signal),
        .raw_button_input (raw_button_input),
        .press_pulse      (press)
    );

    assign red      = link.red_light_active;
    assign yellow   = link.yellow_light_active;
    assign green    = link.green_light_active;
    assign legal    = light_legal({red, yellow, green});
    assign red_rise = red && !red_prev_q;

    // Next-state and registered-output logic; a bad light combination overrides everything.
    always_comb begin
        state_d     = state_q;
        request_d   = request_q;
        walk_d      = walk_q;
        dont_walk_d = dont_walk_q;
        cd_d        = cd_q;
        timer_d     = timer_q;
        pending_d   = pending_q;
        fault_d     = fault_q;
        red_prev_d  = red;
        if (!legal || state_q == FAULT) begin
            state_d     = FAULT;
            fault_d     = 1'b1;
            request_d   = 1'b0;
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            cd_d        = '0;
            timer_d     = '0;
            pending_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    walk_d      = 1'b0;
                    dont_walk_d = 1'b1;
                    cd_d        = '0;
                    if (press || pending_q) begin
                        state_d   = REQUESTED;
                        request_d = 1'b1;
                        pending_d = 1'b0;
                    end
                end
                REQUESTED: begin
                    if (yellow || red) begin
                        state_d   = WAIT_RED;
                        request_d = 1'b0;
                    end
                end
                WAIT_RED: begin
                    if (press) pending_d = 1'b1;
                    if (red_rise) begin
                        state_d     = WALK;
                        walk_d      = 1'b1;
                        dont_walk_d = 1'b0;
                        timer_d     = WALK_LAST;
                    end
                end
                WALK: begin
                    if (press) pending_d = 1'b1;
                    if (!red) begin
                        state_d     = IDLE;
                        walk_d      = 1'b0;
                        dont_walk_d = 1'b1;
                        timer_d     = '0;
                    end else if (timer_q == '0) begin
                        state_d     = CLEAR;
                        walk_d      = 1'b0;
                        dont_walk_d = 1'b1;
                        cd_d        = CLEAR_MAX;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                CLEAR: begin
                    if (press) pending_d = 1'b1;
                    if (!red || cd_q <= DW'(1)) begin
                        state_d     = IDLE;
                        dont_walk_d = 1'b1;
                        cd_d        = '0;
                    end else begin
                        cd_d        = cd_q - DW'(1);
                        dont_walk_d = !dont_walk_q;
                    end
                end
                default: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    // FSM state and all outputs are registered together.
    always_ff @(posedge clock_signal) begin
        if (!reset_n_signal) begin
            state_q     <= IDLE;
            request_q   <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            cd_q        <= '0;
            timer_q     <= '0;
            pending_q   <= 1'b0;
            fault_q     <= 1'b0;
            red_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            request_q   <= request_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            cd_q        <= cd_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            fault_q     <= fault_d;
            red_prev_q  <= red_prev_d;
        end
    end

    assign link.pedestrian_button_pressed = request_q;
    assign walk_light_active              = walk_q;
    assign dont_walk_light_active         = dont_walk_q;
    assign clearance_countdown            = cd_q;
    assign light_fault_detected           = fault_q;

endmodule

// File: tb/tb_pedestrian_crossing_unit.sv
// tb/tb_pedestrian_crossing_unit.sv - directed scoreboard bench for pedestrian_crossing_unit
module tb_pedestrian_crossing_unit;

    logic       clk = 1'b0;
    logic       rstn;
    logic       raw;
    logic       walk;
    logic       dw;
    logic [2:0] cd;
    logic       flt;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    always #10 clk = ~clk;

    pedestrian_crossing_unit_if link();

    pedestrian_crossing_unit #(
        .DEBOUNCE_CYCLES (4),
        .WALK_CYCLES     (8),
        .CLEAR_CYCLES    (6)
    ) dut (
        .clock_signal           (clk),
        .reset_n_signal         (rstn),
        .raw_button_input       (raw),
        .link                   (link),
        .walk_light_active      (walk),
        .dont_walk_light_active (dw),
        .clearance_countdown    (cd),
        .light_fault_detected   (flt)
    );

    function automatic logic [6:0] ev(input logic req, input logic wk, input logic dwl,
                                      input logic [2:0] c, input logic f);
        return {req, wk, dwl, c, f};
    endfunction

    task automatic lights(input logic r, input logic y, input logic g);
        link.red_light_active    = r;
        link.yellow_light_active = y;
        link.green_light_active  = g;
    endtask

    // Push the expectation for the coming edge, then pop and compare once the DUT has updated.
    task automatic cyc(input string tag, input logic [6:0] e);
        logic [6:0] obs;
        logic [6:0] want;
        string      t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #5;
        obs  = {link.pedestrian_button_pressed, walk, dw, cd, flt};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", t, obs, want);
        end
    endtask

    task automatic cycn(input string tag, input int n, input logic [6:0] e);
        for (int i = 0; i < n; i++) cyc(tag, e);
    endtask

    task automatic clear_phase(input string tag);
        for (int i = 0; i < 6; i++) cyc(tag, ev(1'b0, 1'b0, (i % 2 == 0), 3'(6 - i), 1'b0));
    endtask

    initial begin
        logic [6:0] i0;
        logic [6:0] rq;
        logic [6:0] wk;
        logic [6:0] ft;
        i0 = ev(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        rq = ev(1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        wk = ev(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        ft = ev(1'b0, 1'b0, 1'b1, 3'd0, 1'b1);

        rstn = 1'b0;
        raw  = 1'b0;
        lights(1'b0, 1'b0, 1'b1);

        // reset with green lit
        cycn("reset", 3, i0);
        rstn = 1'b1;

        // bounce alone, then steady press: request after edge k+6
        raw = 1'b1; cyc("bounce1", i0);
        raw = 1'b0; cyc("bounce0", i0);
        raw = 1'b1; cyc("bounce1b", i0);
        raw = 1'b0; cyc("bounce0b", i0);
        cycn("bounce_low", 3, i0);
        raw = 1'b1;
        cycn("deb_early", 6, i0);
        cyc("deb_req", rq);

        // full cycle: Y acknowledges, R starts WALK then CLEAR
        raw = 1'b0;
        cyc("req_hold_g", rq);
        lights(1'b0, 1'b1, 1'b0);
        cyc("req_drop_y", i0);
        cyc("wait_y", i0);
        lights(1'b1, 1'b0, 1'b0);
        cycn("walk", 8, wk);
        clear_phase("clear");
        cyc("clr_idle", i0);
        cyc("idle_red", i0);

        // request while red already lit, then red drops during WALK
        raw = 1'b1;
        cycn("p4_early", 6, i0);
        cyc("p4_req", rq);
        cyc("p4_ack_r", i0);
        raw = 1'b0;
        lights(1'b0, 1'b0, 1'b1);
        cycn("p4_green", 2, i0);
        lights(1'b1, 1'b0, 1'b0);
        cycn("p4_walk", 3, wk);
        lights(1'b0, 1'b0, 1'b1);
        cyc("p4_rdrop", i0);
        cyc("p4_nofault", i0);

        // press during WALK is held pending and served after CLEAR
        raw = 1'b1;
        cycn("p5_early", 6, i0);
        cyc("p5_req", rq);
        raw = 1'b0;
        lights(1'b0, 1'b1, 1'b0);
        cyc("p5_ack_y", i0);
        lights(1'b1, 1'b0, 1'b0);
        cyc("p5_walk1", wk);
        raw = 1'b1;
        cycn("p5_walk", 7, wk);
        raw = 1'b0;
        clear_phase("p5_clear");
        cyc("p5_idle", i0);
        cyc("p5_rereq", rq);
        cyc("p5_ack_r", i0);

        // illegal R+Y latches the fault until reset
        lights(1'b1, 1'b1, 1'b0);
        cyc("f_set", ft);
        lights(1'b1, 1'b0, 1'b0);
        cyc("f_hold", ft);
        raw = 1'b1;
        cycn("f_press", 8, ft);
        raw = 1'b0;
        lights(1'b0, 1'b0, 1'b1);
        cyc("f_green", ft);
        lights(1'b1, 1'b0, 1'b0);
        cycn("f_redrise", 2, ft);
        rstn = 1'b0;
        cyc("f_reset", i0);
        rstn = 1'b1;
        cyc("f_after", i0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
